// File: rtl/replacement_policy_ctrl_pkg.sv
// Shared encodings for replacement_policy_ctrl: policy selector, sweep FSM states
// and the per-line replacement state width.
package replacement_policy_ctrl_pkg;

  typedef enum logic [1:0] {
    REPL_LRU       = 2'd0,
    REPL_PLRU_MRU  = 2'd1,
    REPL_PLRU_TREE = 2'd2
  } repl_policy_e;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_READY = 1'b1
  } sweep_state_e;

  function automatic int repl_state_w(repl_policy_e policy, int n_ways, int nway_w);
    case (policy)
      REPL_LRU:      return n_ways * nway_w;
      REPL_PLRU_MRU: return n_ways;
      default:       return n_ways - 1;
    endcase
  endfunction

endpackage

// File: rtl/replacement_policy_ctrl_repl_state_logic.sv
// Combinational per-policy next state, init value and victim selection for one cache line.
// Locked ways are never chosen; with no way locked the choice is the plain policy victim.
module replacement_policy_ctrl_repl_state_logic
  import replacement_policy_ctrl_pkg::*;
#(
  parameter int           N_WAYS     = 8,
  parameter int           NWAY_W     = $clog2(N_WAYS),
  parameter repl_policy_e REP_POLICY = REPL_PLRU_TREE,
  parameter int           STATE_W    = repl_state_w(REP_POLICY, N_WAYS, NWAY_W)
) (
  input  logic [STATE_W-1:0] upd_state,
  input  logic [N_WAYS-1:0]  upd_hit,
  output logic [STATE_W-1:0] upd_next,
  output logic [STATE_W-1:0] init_state,
  input  logic [STATE_W-1:0] sel_state,
  input  logic [N_WAYS-1:0]  lock,
  output logic [N_WAYS-1:0]  victim_way,
  output logic [NWAY_W-1:0]  victim_bin
);
  logic              found;
  logic [NWAY_W-1:0] pick;

  generate
    if (REP_POLICY == REPL_LRU) begin : g_lru
      logic [NWAY_W-1:0] hit_cnt;
      logic [NWAY_W-1:0] best;

      // Counters form a permutation: the hit way becomes newest, younger ones age by one.
      always_comb begin
        upd_next   = upd_state;
        init_state = '0;
        hit_cnt    = '0;
        for (int i = 0; i < N_WAYS; i++)
          if (upd_hit[i]) hit_cnt = upd_state[i*NWAY_W +: NWAY_W];
        for (int i = 0; i < N_WAYS; i++) begin
          init_state[i*NWAY_W +: NWAY_W] = NWAY_W'(i);
          if (upd_hit[i])
            upd_next[i*NWAY_W +: NWAY_W] = NWAY_W'(N_WAYS - 1);
          else if (upd_state[i*NWAY_W +: NWAY_W] > hit_cnt)
            upd_next[i*NWAY_W +: NWAY_W] = upd_state[i*NWAY_W +: NWAY_W] - NWAY_W'(1);
        end
      end

      always_comb begin
        found = 1'b0;
        best  = '0;
        pick  = '0;
        for (int i = 0; i < N_WAYS; i++)
          if (!lock[i] && (!found || sel_state[i*NWAY_W +: NWAY_W] < best)) begin
            found = 1'b1;
            best  = sel_state[i*NWAY_W +: NWAY_W];
            pick  = NWAY_W'(i);
          end
      end
    end else if (REP_POLICY == REPL_PLRU_MRU) begin : g_mru
      logic [N_WAYS-1:0] merged;
      logic              found_zero;
      logic [NWAY_W-1:0] pick_zero;
      logic [NWAY_W-1:0] pick_any;

      always_comb begin
        init_state = '0;
        merged     = upd_state | upd_hit;
        upd_next   = (&merged) ? upd_hit : merged;
      end

      always_comb begin
        found      = 1'b0;
        found_zero = 1'b0;
        pick_zero  = '0;
        pick_any   = '0;
        for (int i = N_WAYS - 1; i >= 0; i--)
          if (!lock[i]) begin
            found    = 1'b1;
            pick_any = NWAY_W'(i);
            if (!sel_state[i]) begin
              found_zero = 1'b1;
              pick_zero  = NWAY_W'(i);
            end
          end
        pick = found_zero ? pick_zero : pick_any;
      end
    end else begin : g_tree
      localparam int LW = NWAY_W + 1;
      logic [N_WAYS-1:0] nxt_tree;
      logic [N_WAYS-1:0] sel_tree;
      logic [NWAY_W-1:0] node;
      logic [LW-1:0]     chosen;

      // True when every leaf below heap node 'sub' (leaf index >> sh == sub) is locked.
      function automatic logic sub_locked(input logic [N_WAYS-1:0] lk,
                                          input logic [LW-1:0] sub, input int sh);
        logic          all_locked;
        logic [LW-1:0] leaf;
        all_locked = 1'b1;
        for (int j = 0; j < N_WAYS; j++) begin
          leaf = LW'(N_WAYS + j);
          if ((leaf >> sh) == sub && !lk[j]) all_locked = 1'b0;
        end
        return all_locked;
      endfunction

      // Heap-ordered nodes live at bit (node-1); padding bit 0 lets the node number index directly.
      always_comb begin
        init_state = '0;
        nxt_tree   = {upd_state, 1'b0};
        for (int w = 0; w < N_WAYS; w++)
          if (upd_hit[w])
            for (int l = 0; l < NWAY_W; l++)
              nxt_tree[NWAY_W'((N_WAYS + w) >> (l + 1))] = (((w >> l) & 1) == 0);
        upd_next = nxt_tree[N_WAYS-1:1];
      end

      always_comb begin
        sel_tree = {sel_state, 1'b0};
        node     = NWAY_W'(1);
        chosen   = '0;
        for (int l = 0; l < NWAY_W; l++) begin
          chosen = {node, sel_tree[node]};
          if (sub_locked(lock, chosen, NWAY_W - 1 - l)) chosen = chosen ^ LW'(1);
          node = chosen[NWAY_W-1:0];
        end
        found = ~&lock;
        pick  = chosen[NWAY_W-1:0];
      end
    end
  endgenerate

  assign victim_bin = found ? pick : '0;
  assign victim_way = found ? (N_WAYS'(1) << pick) : '0;

endmodule

// File: rtl/replacement_policy_ctrl.sv
// Way-replacement controller: sweep-initialised per-line state, registered victim lookup
// and same-cycle forwarded hit updates. Define REPL_WAY_LOCK_EN to add the way_lock port.
module replacement_policy_ctrl
  import replacement_policy_ctrl_pkg::*;
#(
  parameter int           N_WAYS     = 8,
  parameter int           LINE_OFF_W = 7,
  parameter int           NWAY_W     = $clog2(N_WAYS),
  parameter repl_policy_e REP_POLICY = REPL_PLRU_TREE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  lookup_valid,
  input  logic [LINE_OFF_W-1:0] lookup_addr,
  output logic                  lookup_ready,
  output logic                  victim_valid,
  output logic [N_WAYS-1:0]     victim_way,
  output logic [NWAY_W-1:0]     victim_way_bin,
  input  logic                  update_en,
  input  logic [LINE_OFF_W-1:0] update_addr,
  input  logic [N_WAYS-1:0]     update_way_hit,
`ifdef REPL_WAY_LOCK_EN
  input  logic [N_WAYS-1:0]     way_lock,
`endif
  output logic                  busy
);
  localparam int DEPTH   = 2 ** LINE_OFF_W;
  localparam int STATE_W = repl_state_w(REP_POLICY, N_WAYS, NWAY_W);

  sweep_state_e          fsm_state;
  logic [LINE_OFF_W-1:0] sweep_cnt;
  logic [STATE_W-1:0]    state_mem [DEPTH];
  logic [STATE_W-1:0]    upd_next;
  logic [STATE_W-1:0]    init_state;
  logic [STATE_W-1:0]    sel_state;
  logic [N_WAYS-1:0]     lock_mask;
  logic [N_WAYS-1:0]     sel_way;
  logic [NWAY_W-1:0]     sel_bin;
  logic                  update_do;
  logic                  lookup_acc;

`ifdef REPL_WAY_LOCK_EN
  assign lock_mask = way_lock;
`else
  assign lock_mask = '0;
`endif

  // Flush beats a simultaneous update; an all-zero hit vector writes nothing.
  assign update_do  = (fsm_state == ST_READY) && update_en && (|update_way_hit) && !flush;
  assign lookup_acc = lookup_valid && lookup_ready;
  assign sel_state  = (update_do && (update_addr == lookup_addr)) ? upd_next
                                                                   : state_mem[lookup_addr];

  replacement_policy_ctrl_repl_state_logic #(
    .N_WAYS    (N_WAYS),
    .NWAY_W    (NWAY_W),
    .REP_POLICY(REP_POLICY),
    .STATE_W   (STATE_W)
  ) u_state_logic (
    .upd_state (state_mem[update_addr]),
    .upd_hit   (update_way_hit),
    .upd_next  (upd_next),
    .init_state(init_state),
    .sel_state (sel_state),
    .lock      (lock_mask),
    .victim_way(sel_way),
    .victim_bin(sel_bin)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      fsm_state    <= ST_SWEEP;
      sweep_cnt    <= '0;
      lookup_ready <= 1'b0;
      busy         <= 1'b1;
    end else begin
      case (fsm_state)
        ST_SWEEP: begin
          sweep_cnt <= sweep_cnt + LINE_OFF_W'(1);
          if (sweep_cnt == LINE_OFF_W'(DEPTH - 1)) begin
            fsm_state    <= ST_READY;
            lookup_ready <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: fsm_state <= ST_READY;
      endcase
    end
  end

  // The array has no reset; the sweep overwrites every entry before lookups are accepted.
  always_ff @(posedge clk) begin
    if (fsm_state == ST_SWEEP)
      state_mem[sweep_cnt] <= init_state;
    else if (update_do)
      state_mem[update_addr] <= upd_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      victim_valid   <= 1'b0;
      victim_way     <= '0;
      victim_way_bin <= '0;
    end else begin
      victim_valid <= lookup_acc;
      if (lookup_acc) begin
        victim_way     <= sel_way;
        victim_way_bin <= sel_bin;
      end
    end
  end

endmodule

// File: tb/tb_replacement_policy_ctrl.sv
// Directed bench: one 4-way, 4-line instance per policy (LRU, PLRU_mru, PLRU_tree) on shared stimulus.
// Define REPL_WAY_LOCK_EN to include the way-lock steps.
module tb_replacement_policy_ctrl;
  import replacement_policy_ctrl_pkg::*;

  localparam int NW = 4;
  localparam int LW = 2;
  localparam int NB = 2;

  logic          clk            = 1'b0;
  logic          reset          = 1'b1;
  logic          flush          = 1'b0;
  logic          lookup_valid   = 1'b0;
  logic [LW-1:0] lookup_addr    = '0;
  logic          update_en      = 1'b0;
  logic [LW-1:0] update_addr    = '0;
  logic [NW-1:0] update_way_hit = '0;
`ifdef REPL_WAY_LOCK_EN
  logic [NW-1:0] way_lock       = '0;
`endif
  logic [2:0]          ready;
  logic [2:0]          vvalid;
  logic [2:0]          busy_o;
  logic [2:0][NW-1:0]  vway;
  logic [2:0][NB-1:0]  vbin;

  int    errors = 0;
  int    checks = 0;
  int    n;
  string pname [3] = '{"lru", "mru", "tree"};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    replacement_policy_ctrl #(
      .N_WAYS    (NW),
      .LINE_OFF_W(LW),
      .NWAY_W    (NB),
      .REP_POLICY(repl_policy_e'(g))
    ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .lookup_valid  (lookup_valid),
      .lookup_addr   (lookup_addr),
      .lookup_ready  (ready[g]),
      .victim_valid  (vvalid[g]),
      .victim_way    (vway[g]),
      .victim_way_bin(vbin[g]),
      .update_en     (update_en),
      .update_addr   (update_addr),
      .update_way_hit(update_way_hit),
`ifdef REPL_WAY_LOCK_EN
      .way_lock      (way_lock),
`endif
      .busy          (busy_o[g])
    );
  end

  // A multi-hot hit vector is an illegal request from the cache side.
  always @(posedge clk)
    if (!reset && update_en)
      assert ($onehot0(update_way_hit)) else begin
        errors++;
        $error("[TB] FAIL update_way_hit_onehot observed=%b expected=one-hot", update_way_hit);
      end

  function automatic int onehot_to_bin(input logic [NW-1:0] oh);
    int b = 0;
    for (int i = 0; i < NW; i++) if (oh[i]) b = i;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic lv, input logic [LW-1:0] la, input logic ue,
                               input logic [LW-1:0] ua, input logic [NW-1:0] uh, input logic fl);
    lookup_valid   = lv;
    lookup_addr    = la;
    update_en      = ue;
    update_addr    = ua;
    update_way_hit = uh;
    flush          = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkVictim(input string tag, input logic [NW-1:0] e_lru, e_mru, e_tree);
    logic [NW-1:0] exp_w [3];
    exp_w = '{e_lru, e_mru, e_tree};
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("%s_%s_valid", tag, pname[g]), 32'(vvalid[g]), 32'd1);
      checkOutput($sformatf("%s_%s_way", tag, pname[g]), 32'(vway[g]), 32'(exp_w[g]));
      checkOutput($sformatf("%s_%s_bin", tag, pname[g]), 32'(vbin[g]), 32'(onehot_to_bin(exp_w[g])));
    end
  endtask

  task automatic checkReset(input string tag);
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("%s_%s_ready", tag, pname[g]), 32'(ready[g]), 32'd0);
      checkOutput($sformatf("%s_%s_busy", tag, pname[g]), 32'(busy_o[g]), 32'd1);
      checkOutput($sformatf("%s_%s_valid", tag, pname[g]), 32'(vvalid[g]), 32'd0);
      checkOutput($sformatf("%s_%s_way", tag, pname[g]), 32'(vway[g]), 32'd0);
      checkOutput($sformatf("%s_%s_bin", tag, pname[g]), 32'(vbin[g]), 32'd0);
    end
  endtask

  task automatic countSweep(input string tag);
    n = 0;
    while (busy_o[2] && n < 20) begin
      n++;
      tick();
    end
    checkOutput({tag, "_busy_cycles"}, 32'(n), 32'd4);
    checkOutput({tag, "_ready"}, 32'(ready), 32'h7);
    checkOutput({tag, "_busy_low"}, 32'(busy_o), 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    repeat (3) tick();
    checkReset("reset");
    reset = 1'b0;
    countSweep("sweep0");

    applyStimulus(1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    checkVictim("init_a1", 4'b0001, 4'b0001, 4'b0001);

    // Victim outputs hold while no lookup is accepted.
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd1, 4'b0001, 1'b0);
    tick();
    checkOutput("idle_valid", 32'(vvalid), 32'h0);
    checkOutput("idle_hold_way", 32'(vway[2]), 32'h1);

    applyStimulus(1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    checkVictim("hit0_a1", 4'b0010, 4'b0010, 4'b0100);

    applyStimulus(1'b1, 2'd2, 1'b1, 2'd2, 4'b0001, 1'b0);
    tick();
    checkVictim("fwd_hit0_a2", 4'b0010, 4'b0010, 4'b0100);

    applyStimulus(1'b0, 2'd0, 1'b1, 2'd1, 4'b0010, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    checkVictim("hit1_a1", 4'b0100, 4'b0100, 4'b0100);

    applyStimulus(1'b1, 2'd1, 1'b1, 2'd1, 4'b0100, 1'b0);
    tick();
    checkVictim("fwd_hit2_a1", 4'b1000, 4'b1000, 4'b0001);

    applyStimulus(1'b1, 2'd1, 1'b1, 2'd1, 4'b1000, 1'b0);
    tick();
    checkVictim("fwd_hit3_a1", 4'b0001, 4'b0001, 4'b0001);

    applyStimulus(1'b0, 2'd0, 1'b1, 2'd1, 4'b0010, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    checkVictim("b2b_a1", 4'b0001, 4'b0001, 4'b0100);
    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    checkVictim("b2b_a2", 4'b0010, 4'b0010, 4'b0100);

    applyStimulus(1'b1, 2'd3, 1'b1, 2'd3, 4'b0000, 1'b0);
    tick();
    checkVictim("zero_hit_a3", 4'b0001, 4'b0001, 4'b0001);

    applyStimulus(1'b0, 2'd0, 1'b0, 2'd3, 4'b0001, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd3, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    checkVictim("no_en_a3", 4'b0001, 4'b0001, 4'b0001);

    // Flush with a simultaneous update, then lookups held off for the whole sweep.
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd0, 4'b0100, 1'b1);
    tick();
    checkOutput("flush_busy", 32'(busy_o), 32'h7);
    applyStimulus(1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 1'b0);
    n = 0;
    while (ready[2] == 1'b0 && n < 20) begin
      checkOutput($sformatf("flush_no_victim_%0d", n), 32'(vvalid), 32'h0);
      n++;
      tick();
    end
    checkOutput("flush_ready_low_cycles", 32'(n), 32'd4);
    for (int a = 0; a < 4; a++) begin
      applyStimulus(1'b1, LW'(a), 1'b0, 2'd0, 4'b0000, 1'b0);
      tick();
      checkVictim($sformatf("post_flush_a%0d", a), 4'b0001, 4'b0001, 4'b0001);
    end

`ifdef REPL_WAY_LOCK_EN
    way_lock = 4'b0011;
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    checkVictim("lock_0011", 4'b0100, 4'b0100, 4'b0100);
    way_lock = 4'b1111;
    tick();
    checkVictim("lock_all", 4'b0000, 4'b0000, 4'b0000);
    way_lock = 4'b0000;
`endif

    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    checkReset("reset_mid_lookup");
    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkReset("reset_mid_sweep");
    reset = 1'b0;
    countSweep("sweep1");
    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    checkVictim("after_reset_a2", 4'b0001, 4'b0001, 4'b0001);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
